// File: rtl/outstanding_txn_tracker_pkg.sv
// Shared types and parameter defaults for the outstanding transaction tracker.
// Optional stall statistics are enabled with OUTSTANDING_TRACKER_STATS_EN.
package outstanding_txn_tracker_pkg;

    localparam int unsigned DEFAULT_NR_REQ_PORTS    = 2;
    localparam int unsigned DEFAULT_MAX_OUTSTANDING = 7;
    localparam int unsigned DEFAULT_TID_WIDTH       = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } fence_state_e;

endpackage

// File: rtl/outstanding_txn_tracker_tid_scoreboard.sv
// Per-ID busy bitmap with multiple set ports, one clear port and
// combinational lookups of the registered bitmap.
module tid_scoreboard
    import outstanding_txn_tracker_pkg::*;
#(
    parameter int unsigned TidWidth = DEFAULT_TID_WIDTH,
    parameter int unsigned NrSet    = DEFAULT_NR_REQ_PORTS,
    parameter int unsigned NrLookup = DEFAULT_NR_REQ_PORTS + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NrSet-1:0]             set_valid,
    input  logic [NrSet*TidWidth-1:0]    set_tid,
    input  logic                         clr_valid,
    input  logic [TidWidth-1:0]          clr_tid,
    input  logic [NrLookup*TidWidth-1:0] lookup_tid,
    output logic [NrLookup-1:0]          lookup_busy
);

    localparam int unsigned NrIds = 2 ** TidWidth;

    logic [NrIds-1:0] busy_q;
    logic [NrIds-1:0] busy_d;

    // A set and a clear never target the same ID in one cycle: sets need a
    // free ID, clears need a busy one.
    always_comb begin
        busy_d = busy_q;
        if (clr_valid) begin
            busy_d[clr_tid] = 1'b0;
        end
        for (int p = 0; p < NrSet; p++) begin
            if (set_valid[p]) begin
                busy_d[set_tid[p*TidWidth +: TidWidth]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        lookup_busy = '0;
        for (int l = 0; l < NrLookup; l++) begin
            lookup_busy[l] = busy_q[lookup_tid[l*TidWidth +: TidWidth]];
        end
    end

endmodule

// File: rtl/outstanding_txn_tracker.sv
// Tracks in-flight transaction IDs, throttles requests and drains on fence.
// Define OUTSTANDING_TRACKER_STATS_EN to build the saturating stall counter.
module outstanding_txn_tracker
    import outstanding_txn_tracker_pkg::*;
#(
    parameter int unsigned NrReqPorts     = DEFAULT_NR_REQ_PORTS,
    parameter int unsigned MaxOutstanding = DEFAULT_MAX_OUTSTANDING,
    parameter int unsigned TidWidth       = DEFAULT_TID_WIDTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NrReqPorts-1:0]                req_valid_i,
    input  logic [NrReqPorts*TidWidth-1:0]       req_tid_i,
    output logic [NrReqPorts-1:0]                req_ready_o,
    input  logic                                 rsp_valid_i,
    input  logic [TidWidth-1:0]                  rsp_tid_i,
    input  logic                                 fence_i,
    output logic                                 fence_done_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]  cnt_o,
    output logic                                 empty_o,
    output logic                                 err_o,
    output logic [31:0]                          stall_cnt_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    fence_state_e                      state_q;
    fence_state_e                      state_d;
    logic [CntWidth-1:0]               cnt_q;
    logic [CntWidth-1:0]               cnt_d;
    logic                              err_q;
    logic [NrReqPorts-1:0]             accept;
    logic [31:0]                       accept_cnt;
    logic [NrReqPorts:0]               lookup_busy;
    logic [(NrReqPorts+1)*TidWidth-1:0] lookup_tid;
    logic                              rsp_hit;
    logic                              rsp_miss;

    // The last lookup slot checks the completing ID.
    assign lookup_tid = {rsp_tid_i, req_tid_i};
    assign rsp_hit    = rsp_valid_i & lookup_busy[NrReqPorts];
    assign rsp_miss   = rsp_valid_i & ~lookup_busy[NrReqPorts];

    tid_scoreboard #(
        .TidWidth (TidWidth),
        .NrSet    (NrReqPorts),
        .NrLookup (NrReqPorts + 1)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .set_valid   (accept),
        .set_tid     (req_tid_i),
        .clr_valid   (rsp_hit),
        .clr_tid     (rsp_tid_i),
        .lookup_tid  (lookup_tid),
        .lookup_busy (lookup_busy)
    );

    // Ready looks only at registered state and lower-numbered ports, so a
    // same-cycle response never frees a slot or an ID for a request.
    always_comb begin
        req_ready_o = '0;
        accept      = '0;
        accept_cnt  = '0;
        for (int p = 0; p < NrReqPorts; p++) begin
            logic dup;
            dup = 1'b0;
            for (int q = 0; q < NrReqPorts; q++) begin
                if (q < p && accept[q] &&
                    req_tid_i[q*TidWidth +: TidWidth] == req_tid_i[p*TidWidth +: TidWidth]) begin
                    dup = 1'b1;
                end
            end
            req_ready_o[p] = (state_q == IDLE) &&
                             ((32'(cnt_q) + accept_cnt) < MaxOutstanding) &&
                             !lookup_busy[p] && !dup;
            accept[p] = req_valid_i[p] & req_ready_o[p];
            if (accept[p]) begin
                accept_cnt = accept_cnt + 32'd1;
            end
        end
    end

    assign cnt_d = CntWidth'(32'(cnt_q) + accept_cnt - {31'd0, rsp_hit});

    always_comb begin
        state_d      = state_q;
        fence_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (fence_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    fence_done_o = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_q | rsp_miss;
        end
    end

    assign cnt_o   = cnt_q;
    assign empty_o = (cnt_q == '0);
    assign err_o   = err_q;

`ifdef OUTSTANDING_TRACKER_STATS_EN
    logic [31:0] stall_cnt_q;
    logic        stall;

    assign stall = |(req_valid_i & ~req_ready_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (stall && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_outstanding_txn_tracker.sv
// Directed self-checking bench for outstanding_txn_tracker (default parameters).
module tb_outstanding_txn_tracker;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [7:0]  req_tid;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic [3:0]  rsp_tid;
    logic        fence;
    logic        fence_done;
    logic [2:0]  cnt;
    logic        empty;
    logic        err;
    logic [31:0] stall_cnt;

    int testCount = 0;
    int failCount = 0;

    outstanding_txn_tracker dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_tid_i    (req_tid),
        .req_ready_o  (req_ready),
        .rsp_valid_i  (rsp_valid),
        .rsp_tid_i    (rsp_tid),
        .fence_i      (fence),
        .fence_done_o (fence_done),
        .cnt_o        (cnt),
        .empty_o      (empty),
        .err_o        (err),
        .stall_cnt_o  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change just after the falling edge and settle before sampling.
    task automatic applyStimulus(input logic [1:0] v, input logic [3:0] t0, input logic [3:0] t1,
                                 input logic rv, input logic [3:0] rt, input logic f);
        @(negedge clk);
        req_valid = v;
        req_tid   = {t1, t0};
        rsp_valid = rv;
        rsp_tid   = rt;
        fence     = f;
        #2;
    endtask

    initial begin
        int unsigned expStall;
        rst_n     = 1'b0;
        req_valid = '0;
        req_tid   = '0;
        rsp_valid = 1'b0;
        rsp_tid   = '0;
        fence     = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        checkOutput("reset_cnt", 32'(cnt), 0);
        checkOutput("reset_empty", 32'(empty), 1);
        checkOutput("reset_err", 32'(err), 0);
        checkOutput("reset_fence_done", 32'(fence_done), 0);
        checkOutput("reset_stall", stall_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Response for an idle ID raises the sticky error.
        applyStimulus(2'b00, 0, 0, 1, 5, 0);
        applyStimulus(2'b00, 0, 0, 0, 0, 0);
        checkOutput("err_set", 32'(err), 1);
        checkOutput("err_cnt_same", 32'(cnt), 0);

        // Both ports want ID 3: only port 0 wins.
        applyStimulus(2'b11, 3, 3, 0, 0, 0);
        checkOutput("dup_ready", 32'(req_ready), 32'b01);
        applyStimulus(2'b00, 0, 0, 1, 3, 0);
        checkOutput("dup_cnt", 32'(cnt), 1);
        applyStimulus(2'b00, 0, 0, 0, 0, 0);
        checkOutput("dup_clear_cnt", 32'(cnt), 0);
        checkOutput("dup_clear_empty", 32'(empty), 1);

        // Fill to the limit with IDs 0..6.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'b01, 4'(i), 0, 0, 0, 0);
            checkOutput($sformatf("fill_ready_%0d", i), 32'(req_ready), 32'b01);
        end
        applyStimulus(2'b11, 6, 7, 0, 0, 0);
        checkOutput("fill_cnt6", 32'(cnt), 6);
        checkOutput("limit_ready", 32'(req_ready), 32'b01);
        applyStimulus(2'b11, 7, 8, 0, 0, 0);
        checkOutput("full_cnt", 32'(cnt), 7);
        checkOutput("full_ready", 32'(req_ready), 32'b00);
        checkOutput("full_empty", 32'(empty), 0);

        // Same-cycle response never frees capacity or the ID for a request.
        applyStimulus(2'b01, 9, 9, 1, 2, 0);
        checkOutput("rsp_full_ready", 32'(req_ready), 32'b00);
        applyStimulus(2'b11, 4, 4, 1, 4, 0);
        checkOutput("rsp_full_cnt", 32'(cnt), 6);
        checkOutput("rsp_same_id_ready", 32'(req_ready), 32'b00);
        applyStimulus(2'b00, 0, 0, 1, 0, 0);
        checkOutput("rsp_same_id_cnt", 32'(cnt), 5);
        applyStimulus(2'b00, 0, 0, 1, 1, 0);
        applyStimulus(2'b00, 0, 0, 1, 3, 0);

        // Fence with IDs 5 and 6 in flight.
        applyStimulus(2'b00, 0, 0, 0, 0, 1);
        checkOutput("fence_cnt", 32'(cnt), 2);
        checkOutput("fence_done_idle", 32'(fence_done), 0);
        applyStimulus(2'b11, 7, 8, 1, 5, 0);
        checkOutput("drain_ready", 32'(req_ready), 32'b00);
        checkOutput("drain_done_cnt2", 32'(fence_done), 0);
        applyStimulus(2'b00, 0, 0, 1, 6, 0);
        checkOutput("drain_cnt1", 32'(cnt), 1);
        checkOutput("drain_done_cnt1", 32'(fence_done), 0);
        applyStimulus(2'b01, 7, 7, 0, 0, 0);
        checkOutput("drain_done_pulse", 32'(fence_done), 1);
        checkOutput("drain_done_ready", 32'(req_ready), 32'b00);
        applyStimulus(2'b01, 7, 7, 0, 0, 0);
        checkOutput("after_drain_done", 32'(fence_done), 0);
        checkOutput("after_drain_ready", 32'(req_ready), 32'b01);
        checkOutput("err_sticky", 32'(err), 1);
        applyStimulus(2'b00, 0, 0, 0, 0, 0);
        checkOutput("after_drain_cnt", 32'(cnt), 1);

        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checkOutput("reset2_err", 32'(err), 0);
        checkOutput("reset2_cnt", 32'(cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Port 0 blocked for 10 cycles while draining.
        applyStimulus(2'b01, 7, 7, 0, 0, 0);
        checkOutput("stats_accept_ready", 32'(req_ready), 32'b01);
        applyStimulus(2'b00, 0, 0, 0, 0, 1);
        checkOutput("stats_cnt", 32'(cnt), 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(2'b01, 8, 8, 0, 0, 0);
            checkOutput($sformatf("stats_blocked_%0d", i), 32'(req_ready), 32'b00);
        end
        applyStimulus(2'b00, 0, 0, 0, 0, 0);
`ifdef OUTSTANDING_TRACKER_STATS_EN
        expStall = 10;
`else
        expStall = 0;
`endif
        checkOutput("stall_cnt", stall_cnt, expStall);
        checkOutput("mid_drain_done", 32'(fence_done), 0);

        // Reset in the middle of the drain.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checkOutput("mid_reset_cnt", 32'(cnt), 0);
        checkOutput("mid_reset_empty", 32'(empty), 1);
        checkOutput("mid_reset_err", 32'(err), 0);
        checkOutput("mid_reset_done", 32'(fence_done), 0);
        checkOutput("mid_reset_stall", stall_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2'b00, 0, 0, 1, 7, 0);
        checkOutput("post_reset_done0", 32'(fence_done), 0);
        applyStimulus(2'b00, 0, 0, 0, 0, 0);
        checkOutput("post_reset_done1", 32'(fence_done), 0);
        checkOutput("post_reset_err", 32'(err), 1);
        checkOutput("post_reset_cnt", 32'(cnt), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/outstanding_txn_tracker.md
OUTSTANDING_TXN_TRACKER -- requirements
Module: outstanding_txn_tracker

Interface
REQ-001 SHALL have parameter NrReqPorts, default 2, number of request ports accepted per cycle (legal 1..2).
REQ-002 SHALL have parameter MaxOutstanding, default 7, maximum in-flight transactions (legal 1..255).
REQ-003 SHALL have parameter TidWidth, default 4, width of the transaction ID.
REQ-004 SHALL have the port clk_i  in  1  sole clock, rising edge.
REQ-005 SHALL have the port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have the port req_valid_i  in  NrReqPorts  per-port request valid.
REQ-007 SHALL have the port req_tid_i  in  NrReqPorts x TidWidth  per-port request ID.
REQ-008 SHALL have the port req_ready_o  out  NrReqPorts  per-port accept.
REQ-009 SHALL have the port rsp_valid_i  in  1  completion strobe.
REQ-010 SHALL have the port rsp_tid_i  in  TidWidth  completing ID.
REQ-011 SHALL have the port fence_i  in  1  drain request, single-cycle pulse.
REQ-012 SHALL have the port fence_done_o  out  1  drain complete, single-cycle pulse.
REQ-013 SHALL have the port cnt_o  out  $clog2(MaxOutstanding+1)  current in-flight count.
REQ-014 SHALL have the port empty_o  out  1  cnt_o == 0.
REQ-015 SHALL have the port err_o  out  1  sticky protocol error.
REQ-016 SHALL have the port stall_cnt_o  out  32  stall statistics (see Configuration).

Function
REQ-017 SHALL keep a per-ID busy bitmap of 2**TidWidth bits and a count register.
REQ-018 SHALL accept port p when req_valid_i[p] & req_ready_o[p]; acceptance is the handshake, with no valid-before-ready dependency.
REQ-019 SHALL drive req_ready_o[p] high only if: FSM is IDLE; cnt_q plus the number of lower-numbered ports accepted this cycle is below MaxOutstanding; busy[req_tid_i[p]]==0; and no lower-numbered port is accepting the same ID this cycle.
REQ-020 SHALL exclude same-cycle responses from ready computation (ready depends only on registered state and lower-port requests).
REQ-021 SHALL, on acceptance, set busy[tid] and increment the count in the next cycle.
REQ-022 SHALL, on rsp_valid_i with busy[rsp_tid_i]==1, clear the bit and decrement the count.
REQ-023 SHALL apply accepts and a response in the same cycle as a net count change; a response clearing ID X while a port requests X SHALL still leave that port not ready.
REQ-024 SHALL, on rsp_valid_i with busy[rsp_tid_i]==0, set err_o sticky and leave count and bitmap unchanged.
REQ-025 SHALL implement a fence FSM with states IDLE and DRAIN: IDLE->DRAIN on fence_i.
REQ-026 SHALL, in DRAIN with cnt_q==0, pulse fence_done_o combinationally and return to IDLE next cycle; minimum fence latency is 1 cycle.
REQ-027 SHALL ignore fence_i while in DRAIN.
REQ-028 SHALL drive cnt_o and empty_o from registered state only.

Reset
REQ-029 SHALL, while rst_ni is low, force FSM=IDLE, count=0, bitmap=0, err_o=0, stall_cnt_o=0, fence_done_o=0.
REQ-030 SHALL drop any in-progress drain on reset and never emit fence_done_o for it.

Configuration
REQ-031 SHALL, with OUTSTANDING_TRACKER_STATS_EN defined, increment stall_cnt_o (saturating at 2**32-1) each cycle any req_valid_i[p] & !req_ready_o[p].
REQ-032 SHALL, without OUTSTANDING_TRACKER_STATS_EN, tie stall_cnt_o to 0 and instantiate no counter flops.

Structure
REQ-033 SHALL place the FSM state enum and parameter defaults in package outstanding_txn_tracker_pkg.
REQ-034 SHALL implement the bitmap as sub-module tid_scoreboard (set ports, clear port, lookup ports).

Verification
REQ-035 SHALL cover: 7 accepts with IDs 0..6, no responses -> cnt_o=7, req_ready_o=00 on the 8th request.
REQ-036 SHALL cover: ports 0 and 1 both request ID 3 -> port0 accepted, port1 not ready, cnt_o=1 next cycle.
REQ-037 SHALL cover: cnt_o=7, a response for ID 2 plus a port0 request for ID 9 in one cycle -> ready=0, cnt_o=6 next cycle.
REQ-038 SHALL cover: cnt_o=2, then fence_i -> ready=00; after responses for both IDs, fence_done_o pulses in the cycle after the last response, and FSM is IDLE in the following cycle.
REQ-039 SHALL cover: a response for ID 5 while it is not busy -> err_o=1 and it stays 1 until reset, cnt_o unchanged.
REQ-040 SHALL cover: with STATS_EN defined, 10 cycles of port0 blocked -> stall_cnt_o=10; assert rst_ni low mid-drain -> all outputs 0 and no fence_done_o.
